// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache.
// Lines are 16 bytes; misses move whole blocks over a 128-bit memory handshake.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [3:0]   READ_EN,
  input  logic [2:0]   WRITE_EN,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITE_DATA,
  output logic [31:0]  READ_DATA,
  output logic         BUSY_WAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITE_DATA,
  input  logic [127:0] MEM_READ_DATA,
  input  logic         MEM_BUSY_WAIT
);

  localparam int TAG_BITS = 32 - 4 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    ALLOCATE,
    UPDATE
  } state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG_BITS-1:0] tag_array_q  [LINES];
  logic [TAG_BITS-1:0] tag_array_d  [LINES];
  logic [127:0]        data_array_q [LINES];
  logic [127:0]        data_array_d [LINES];
  logic [127:0]        refill_q, refill_d;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            word;
  logic                  store_req;
  logic                  load_req;
  logic                  req;
  logic                  hit;
  logic [127:0]          line;
  logic [31:0]           line_word;

  // Select a byte or halfword lane from a word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'd0} +: 8];
    h = w[{lo[1], 4'd0} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Merge store data into a word, leaving unselected byte lanes untouched.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{lo, 3'd0} +: 8]     = wd[7:0];
      2'b01:   r[{lo[1], 4'd0} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign index     = ADDRESS[4 +: INDEX_BITS];
  assign tag       = ADDRESS[31 -: TAG_BITS];
  assign word      = ADDRESS[3:2];
  assign store_req = WRITE_EN[2];
  assign load_req  = READ_EN[3] & ~WRITE_EN[2];
  assign req       = READ_EN[3] | WRITE_EN[2];
  assign line      = data_array_q[index];
  assign line_word = line[{word, 5'd0} +: 32];
  assign hit       = valid_q[index] && (tag_array_q[index] == tag);

  // Next-state, array updates and all outputs; hits complete with zero stall.
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_array_d    = tag_array_q;
    data_array_d   = data_array_q;
    refill_d       = refill_q;
    READ_DATA      = '0;
    BUSY_WAIT      = 1'b0;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          BUSY_WAIT = 1'b1;
          state_d   = dirty_q[index] ? WRITE_BACK : ALLOCATE;
        end else if (req) begin
          if (load_req) begin
            READ_DATA = load_extend(line_word, READ_EN[2:0], ADDRESS[1:0]);
          end
          // A store landing on the reset edge is dropped with the line state.
          if (store_req && !RESET) begin
            data_array_d[index][{word, 5'd0} +: 32] =
              store_merge(line_word, WRITE_DATA, WRITE_EN[1:0], ADDRESS[1:0]);
            dirty_d[index] = 1'b1;
          end
        end
      end
      WRITE_BACK: begin
        BUSY_WAIT      = 1'b1;
        MEM_WRITE      = 1'b1;
        MEM_ADDRESS    = {tag_array_q[index], index};
        MEM_WRITE_DATA = line;
        if (!MEM_BUSY_WAIT) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        BUSY_WAIT   = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[31:4];
        if (!MEM_BUSY_WAIT) begin
          refill_d = MEM_READ_DATA;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        BUSY_WAIT = 1'b1;
        if (!RESET) begin
          data_array_d[index] = refill_q;
          tag_array_d[index]  = tag;
          valid_d[index]      = 1'b1;
          dirty_d[index]      = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM and per-line valid/dirty bits, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag/data storage and the refill capture buffer; contents survive reset.
  always_ff @(posedge CLK) begin
    tag_array_q  <= tag_array_d;
    data_array_q <= data_array_d;
    refill_q     <= refill_d;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scenarios plus randomized loads/stores checked
// against a flat byte-memory model and a set-occupancy model of the cache.
module tb_dcache_controller;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [3:0]   READ_EN;
  logic [2:0]   WRITE_EN;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITE_DATA;
  logic [31:0]  READ_DATA;
  logic         BUSY_WAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITE_DATA;
  logic [127:0] MEM_READ_DATA;
  logic         MEM_BUSY_WAIT;

  dcache_controller #(.INDEX_BITS(3)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .READ_EN        (READ_EN),
    .WRITE_EN       (WRITE_EN),
    .ADDRESS        (ADDRESS),
    .WRITE_DATA     (WRITE_DATA),
    .READ_DATA      (READ_DATA),
    .BUSY_WAIT      (BUSY_WAIT),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .MEM_ADDRESS    (MEM_ADDRESS),
    .MEM_WRITE_DATA (MEM_WRITE_DATA),
    .MEM_READ_DATA  (MEM_READ_DATA),
    .MEM_BUSY_WAIT  (MEM_BUSY_WAIT)
  );

  always #5 CLK = ~CLK;

  // Main memory: 64 blocks (byte addresses 0x000-0x3FF); each transfer takes lat cycles.
  logic [127:0] bmem [64];
  int lat  = 1;
  int mcnt = 0;
  assign MEM_BUSY_WAIT = (MEM_READ || MEM_WRITE) && (mcnt < lat - 1);
  assign MEM_READ_DATA = bmem[MEM_ADDRESS[5:0]];
  always @(posedge CLK) begin
    if ((MEM_READ || MEM_WRITE) && MEM_BUSY_WAIT) mcnt <= mcnt + 1;
    else mcnt <= 0;
    if (MEM_WRITE && !MEM_BUSY_WAIT) bmem[MEM_ADDRESS[5:0]] <= MEM_WRITE_DATA;
  end

  // Reference: what the CPU should see (coherent byte memory) and which block each set holds.
  logic [7:0]  ref_mem [1024];
  logic        rv   [8];
  logic        rd   [8];
  logic [24:0] rtag [8];
  logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  int          vectors = 0;
  int          errors  = 0;
  int          last_busy;
  logic [31:0] last_rdata;
  logic [31:0] last_wb_word0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    int          b;
    logic [15:0] h;
    case (f3)
      3'b000: return {{24{ref_mem[a][7]}}, ref_mem[a]};
      3'b100: return {24'd0, ref_mem[a]};
      3'b001, 3'b101: begin
        b = a & ~1;
        h = {ref_mem[b+1], ref_mem[b]};
        return f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      end
      default: begin
        b = a & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
      end
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int b;
    case (sz)
      2'b00: ref_mem[a] = wd[7:0];
      2'b01: begin
        b = a & ~1;
        ref_mem[b]   = wd[7:0];
        ref_mem[b+1] = wd[15:8];
      end
      default: begin
        b = a & ~3;
        for (int j = 0; j < 4; j++) ref_mem[b+j] = wd[8*j +: 8];
      end
    endcase
  endtask

  function automatic logic [127:0] ref_block(input int baddr);
    logic [127:0] blk;
    for (int j = 0; j < 16; j++) blk[8*j +: 8] = ref_mem[baddr*16 + j];
    return blk;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      rv[i] = 1'b0;
      rd[i] = 1'b0;
    end
    for (int b = 0; b < 64; b++)
      for (int j = 0; j < 16; j++) ref_mem[b*16 + j] = bmem[b][8*j +: 8];
  endtask

  // Pulse reset with no request pending and check the quiescent outputs.
  task automatic do_reset();
    RESET    = 1'b1;
    READ_EN  = '0;
    WRITE_EN = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy",   BUSY_WAIT,      '0);
    check("rst_mrd",    MEM_READ,       '0);
    check("rst_mwr",    MEM_WRITE,      '0);
    check("rst_maddr",  MEM_ADDRESS,    '0);
    check("rst_mwdata", MEM_WRITE_DATA, '0);
    check("rst_rdata",  READ_DATA,      '0);
    @(posedge CLK); #1;
    model_reset();
  endtask

  // Apply one CPU request (called just after a posedge) and follow it to completion.
  task automatic do_req(input logic [3:0] re, input logic [2:0] we, input logic [31:0] a,
                        input logic [31:0] wd, input int mlat);
    int           idx;
    logic [24:0]  tg;
    logic         isreq, ld, hit, dty;
    int           wb_cyc, stall;
    logic [127:0] exp_wb;
    logic [27:0]  exp_wb_addr;
    idx    = int'(a[6:4]);
    tg     = a[31:7];
    isreq  = re[3] | we[2];
    ld     = re[3] & ~we[2];
    hit    = rv[idx] && (rtag[idx] == tg);
    dty    = rv[idx] && rd[idx];
    wb_cyc = (isreq && !hit && dty) ? mlat : 0;
    stall  = (!isreq || hit) ? 0 : 2 + mlat + wb_cyc;
    exp_wb_addr = {rtag[idx], a[6:4]};
    exp_wb      = (wb_cyc > 0) ? ref_block(int'(exp_wb_addr[5:0])) : '0;
    lat        = mlat;
    READ_EN    = re;
    WRITE_EN   = we;
    ADDRESS    = a;
    WRITE_DATA = wd;
    last_busy     = 0;
    last_wb_word0 = '0;
    for (int k = 0; k <= stall; k++) begin
      @(negedge CLK);
      if (BUSY_WAIT) last_busy++;
      if (k == stall) begin
        check("done_busy", BUSY_WAIT, '0);
        check("done_mrd",  MEM_READ,  '0);
        check("done_mwr",  MEM_WRITE, '0);
        check("read_data", READ_DATA, ld ? ref_load(re[2:0], int'(a)) : 32'd0);
        last_rdata = READ_DATA;
      end else begin
        check("stall_busy", BUSY_WAIT, 1'b1);
        if (k >= 1 && k <= wb_cyc) begin
          check("wb_mwr",   MEM_WRITE,      1'b1);
          check("wb_mrd",   MEM_READ,       '0);
          check("wb_addr",  MEM_ADDRESS,    exp_wb_addr);
          check("wb_data",  MEM_WRITE_DATA, exp_wb);
          last_wb_word0 = MEM_WRITE_DATA[31:0];
        end else if (k > wb_cyc && k <= wb_cyc + mlat) begin
          check("alloc_mrd",  MEM_READ,    1'b1);
          check("alloc_mwr",  MEM_WRITE,   '0);
          check("alloc_addr", MEM_ADDRESS, a[31:4]);
        end else begin
          check("quiet_mrd", MEM_READ,  '0);
          check("quiet_mwr", MEM_WRITE, '0);
        end
        @(posedge CLK); #1;
      end
    end
    @(posedge CLK); #1;
    if (isreq) begin
      if (!hit) begin
        rtag[idx] = tg;
        rv[idx]   = 1'b1;
        rd[idx]   = 1'b0;
      end
      if (we[2]) begin
        ref_store(we[1:0], int'(a), wd);
        rd[idx] = 1'b1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [3:0]  re;
    logic [2:0]  we;
    logic [31:0] a;
    logic [31:0] wd;
    int          kind;
    RESET      = 1'b1;
    READ_EN    = '0;
    WRITE_EN   = '0;
    ADDRESS    = '0;
    WRITE_DATA = '0;
    for (int b = 0; b < 64; b++) bmem[b] = {$urandom, $urandom, $urandom, $urandom};
    bmem[4] = {32'h44, 32'h33, 32'h22, 32'h11};
    do_reset();

    // Clean miss on LW 0x40, zero-wait memory.
    do_req(4'b1010, 3'b000, 32'h40, 32'h0, 1);
    check("tp_lw40",      last_rdata, 32'h11);
    check("tp_miss_stall", last_busy, 3);

    // Zero-stall hit loads on word 1 = 0x000080F0.
    do_req(4'b0000, 3'b110, 32'h44, 32'h000080F0, 1);
    do_req(4'b1000, 3'b000, 32'h44, 32'h0, 1);
    check("tp_lb44",  last_rdata, 32'hFFFFFFF0);
    check("tp_hit_stall", last_busy, 0);
    do_req(4'b1100, 3'b000, 32'h44, 32'h0, 1);
    check("tp_lbu44", last_rdata, 32'h000000F0);
    do_req(4'b1001, 3'b000, 32'h45, 32'h0, 1);
    check("tp_lh45",  last_rdata, 32'hFFFF80F0);
    do_req(4'b1101, 3'b000, 32'h46, 32'h0, 1);
    check("tp_lhu46", last_rdata, 32'h00000000);

    // Store byte then read back the word.
    do_req(4'b0000, 3'b100, 32'h41, 32'h000000AB, 1);
    do_req(4'b1010, 3'b000, 32'h40, 32'h0, 1);
    check("tp_sb_lw40", last_rdata, 32'h0000AB11);

    // Dirty eviction with a 2-cycle memory.
    do_req(4'b1010, 3'b000, 32'hC0, 32'h0, 2);
    check("tp_wb_word0",   last_wb_word0, 32'h0000AB11);
    check("tp_dirty_stall", last_busy, 6);

    // Reset while ALLOCATE is in progress.
    lat     = 3;
    READ_EN = 4'b1010;
    ADDRESS = 32'h100;
    @(negedge CLK);
    check("tp_rst_idle_busy", BUSY_WAIT, 1'b1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("tp_rst_alloc_mrd", MEM_READ, 1'b1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET   = 1'b0;
    READ_EN = '0;
    @(negedge CLK);
    check("tp_rst_mrd",  MEM_READ,  '0);
    check("tp_rst_busy", BUSY_WAIT, '0);
    @(posedge CLK); #1;
    model_reset();
    do_req(4'b1010, 3'b000, 32'h40, 32'h0, 1);
    check("tp_post_rst_miss", last_busy, 3);

    // Simultaneous load and store: store wins, READ_DATA is zero.
    do_req(4'b1010, 3'b110, 32'h40, 32'hDEADBEEF, 1);
    check("tp_both_rdata", last_rdata, 32'h0);
    do_req(4'b1010, 3'b000, 32'h40, 32'h0, 1);
    check("tp_both_lw40", last_rdata, 32'hDEADBEEF);

    // Randomized traffic over 1 KB: 8 sets, 8 competing tags per set.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        kind = int'($urandom_range(0, 9));
        a    = $urandom_range(0, 1023);
        wd   = $urandom;
        re   = '0;
        we   = '0;
        if (kind >= 1 && kind <= 4) begin
          re = {1'b1, f3_tab[$urandom_range(0, 4)]};
        end else if (kind >= 5 && kind <= 8) begin
          we = {1'b1, 2'($urandom_range(0, 2))};
        end else if (kind == 9) begin
          re = {1'b1, f3_tab[$urandom_range(0, 4)]};
          we = {1'b1, 2'($urandom_range(0, 2))};
        end
        do_req(re, we, a, wd, int'($urandom_range(1, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
